// File: rtl/fetch_channel_writer.sv
// Fetch-side producer of the decoder instruction channel: credit-limited sequential
// fetch into a DEPTH-entry PC-tagged FIFO, with redirect flush and in-flight discard.
module fetch_channel_writer #(
   parameter  int                 XPR_LEN  = 32,
   parameter  int                 DEPTH    = 4,
   parameter  logic [XPR_LEN-1:0] RESET_PC = '0,
   localparam int                 CW       = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               redirect_valid,
   input  logic [XPR_LEN-1:0] redirect_pc,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [XPR_LEN-1:0] imem_req_addr,
   input  logic               imem_resp_valid,
   input  logic [XPR_LEN-1:0] imem_resp_data,
   output logic               dec_valid,
   input  logic               dec_ready,
   output logic [XPR_LEN-1:0] dec_inst,
   output logic [XPR_LEN-1:0] dec_pc,
   output logic [CW-1:0]      dec_count
);

   localparam int                 PW        = $clog2(DEPTH);
   localparam logic [CW:0]        L_DEPTH   = (CW + 1)'(DEPTH);
   localparam logic [CW-1:0]      L_ONE_C   = CW'(1);
   localparam logic [PW-1:0]      L_ONE_P   = PW'(1);
   localparam logic [XPR_LEN-1:0] L_PC_STEP = XPR_LEN'(4);
   localparam logic [XPR_LEN-1:0] L_PC_MASK = ~XPR_LEN'(3);

   logic [XPR_LEN-1:0] r_fetch_pc;
   logic [XPR_LEN-1:0] r_resp_pc;
   logic [CW-1:0]      r_outstanding;
   logic [CW-1:0]      r_discard;
   logic [CW-1:0]      r_count;
   logic [PW-1:0]      r_wr_ptr;
   logic [PW-1:0]      r_rd_ptr;
   logic               r_run;
   logic [XPR_LEN-1:0] r_fifo_inst [DEPTH];
   logic [XPR_LEN-1:0] r_fifo_pc   [DEPTH];

   logic [CW:0]        w_credit_sum;
   logic               w_req_hs;
   logic               w_push;
   logic               w_drop;
   logic               w_pop;
   logic [CW-1:0]      w_outstanding_next;
   logic [XPR_LEN-1:0] w_redirect_pc;

   // Outstanding requests reserve a slot each, so a live response can always be written.
   assign w_credit_sum   = {1'b0, r_outstanding} + {1'b0, r_count};
   assign imem_req_valid = r_run & ~redirect_valid & (w_credit_sum < L_DEPTH);
   assign imem_req_addr  = r_fetch_pc;
   assign w_req_hs       = imem_req_valid & imem_req_ready;

   assign w_push = imem_resp_valid & ~redirect_valid & (r_discard == '0);
   assign w_drop = imem_resp_valid & ~redirect_valid & (r_discard != '0);
   assign w_pop  = dec_valid & dec_ready & ~redirect_valid;

   assign w_outstanding_next = r_outstanding + CW'(w_req_hs) - CW'(imem_resp_valid);
   assign w_redirect_pc      = redirect_pc & L_PC_MASK;

   assign dec_valid = (r_count != '0);
   assign dec_count = r_count;
   assign dec_inst  = r_fifo_inst[r_rd_ptr];
   assign dec_pc    = r_fifo_pc[r_rd_ptr];

   // NOTE: state registers use non-blocking assignments so every update in this block
   // sees the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_count       <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_run         <= 1'b0;
      end else begin
         r_run         <= 1'b1;
         r_outstanding <= w_outstanding_next;
         if (redirect_valid) begin
            // Every request still in flight after this cycle belongs to the old stream.
            r_fetch_pc <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
            r_discard  <= w_outstanding_next;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
         end else begin
            if (w_req_hs) r_fetch_pc <= r_fetch_pc + L_PC_STEP;
            if (w_drop)   r_discard  <= r_discard - L_ONE_C;
            if (w_push) begin
               r_wr_ptr  <= r_wr_ptr + L_ONE_P;
               r_resp_pc <= r_resp_pc + L_PC_STEP;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + L_ONE_P;
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + L_ONE_C;
               2'b01:   r_count <= r_count - L_ONE_C;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // NOTE: FIFO storage has no reset; dec_valid masks stale entries, and leaving it out
   // keeps the array as plain registers without reset fan-out.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_inst[r_wr_ptr] <= imem_resp_data;
         r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
      end
   end

endmodule
